// File: rtl/ks_adder_pipe_if.sv
// Purpose: valid/ready stream bundle for ks_adder_pipe (operand beat in, sum beat out).
// Latency: none, this is wiring only.
// Backpressure: in_ready/out_ready follow standard valid/ready; a beat moves when valid && ready.
//
// Ports (signals):
//   in_valid/in_ready   operand beat handshake
//   in0, in1            unsigned operands, WIDTH bits
//   cin                 carry-in
//   out_valid/out_ready result handshake
//   out0                WIDTH+1 bit sum, MSB is carry-out
interface ks_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out0;

    // Producer/consumer side: drives operands, accepts results.
    modport master (
        output in_valid, in0, in1, cin, out_ready,
        input  in_ready, out_valid, out0
    );

    // Adder side.
    modport slave (
        input  in_valid, in0, in1, cin, out_ready,
        output in_ready, out_valid, out0
    );
endinterface

// File: rtl/ks_adder_pipe.sv
// Purpose: fully pipelined Kogge-Stone adder, out0 = in0 + in1 + cin (WIDTH+1 bits).
// Latency: $clog2(WIDTH)+2 cycles from the cycle a beat is accepted to the cycle it is valid at out0.
// Backpressure: global stall; whole pipe freezes while out_valid && !out_ready, in_ready = !stall.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears every valid bit and out0
//   bus  ks_adder_pipe_if.slave: in_valid/in_ready/in0/in1/cin, out_valid/out_ready/out0
//
// Pipeline layout (index 0..LEVELS of the stage arrays):
//   stage 0       operands registered as bitwise (g, p); cin already folded into g[0]
//   stage k>=1    prefix level k applied, span 2^(k-1)
//   out0 register sum bits and carry-out
module ks_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    ks_adder_pipe_if.slave bus
);

    localparam int LEVELS = $clog2(WIDTH);

    typedef logic [WIDTH-1:0] word_t;

    // Group generate / group propagate after each level.
    word_t gg_q  [LEVELS+1];
    word_t gg_d  [LEVELS+1];
    word_t gp_q  [LEVELS+1];
    word_t gp_d  [LEVELS+1];
    // Original bitwise propagate and carry-in, carried alongside for the sum stage.
    word_t p_q   [LEVELS+1];
    word_t p_d   [LEVELS+1];
    logic  cin_q [LEVELS+1];
    logic  cin_d [LEVELS+1];
    // Per-stage valid bits.
    logic  vld_q [LEVELS+1];
    logic  vld_d [LEVELS+1];

    logic [WIDTH:0] out0_q;
    logic [WIDTH:0] out0_d;
    logic           out_vld_q;
    logic           out_vld_d;

    logic  en;
    word_t carry;
    word_t sum;
    word_t ones;
    word_t low_mask;
    word_t g_shift;
    word_t p_shift;
    word_t bit_g;
    word_t bit_p;

    // The only thing that can stop the pipe is a result sitting unaccepted at
    // the output; every stage (full or bubble) moves together otherwise.
    assign en           = !(out_vld_q && !bus.out_ready);
    assign bus.in_ready = en;
    assign bus.out_valid = out_vld_q;
    assign bus.out0      = out0_q;

    always_comb begin
        // Hold everything by default; a stall simply keeps these values.
        for (int k = 0; k <= LEVELS; k++) begin
            gg_d[k]  = gg_q[k];
            gp_d[k]  = gp_q[k];
            p_d[k]   = p_q[k];
            cin_d[k] = cin_q[k];
            vld_d[k] = vld_q[k];
        end
        out0_d    = out0_q;
        out_vld_d = out_vld_q;
        ones      = '1;
        low_mask  = '0;
        g_shift   = '0;
        p_shift   = '0;
        carry     = '0;
        sum       = '0;
        bit_g     = bus.in0 & bus.in1;
        bit_p     = bus.in0 ^ bus.in1;

        if (en) begin
            // Stage 0: bitwise generate/propagate. Folding cin into g[0] makes
            // the prefix tree produce carries that already include carry-in.
            bit_g[0] = (bus.in0[0] & bus.in1[0]) | ((bus.in0[0] ^ bus.in1[0]) & bus.cin);
            gg_d[0]  = bit_g;
            gp_d[0]  = bit_p;
            p_d[0]   = bit_p;
            cin_d[0] = bus.cin;
            vld_d[0] = bus.in_valid && en;

            // Prefix levels. Shifting by the span lines bit i up with bit
            // i-span. For the low 'span' bits the shifted-in zeros leave G
            // unchanged, and OR-ing the low mask into the shifted P leaves P
            // unchanged, which is exactly the pass-through case.
            for (int k = 1; k <= LEVELS; k++) begin
                low_mask = ~(ones << (1 << (k - 1)));
                g_shift  = gg_q[k-1] << (1 << (k - 1));
                p_shift  = (gp_q[k-1] << (1 << (k - 1))) | low_mask;
                gg_d[k]  = gg_q[k-1] | (gp_q[k-1] & g_shift);
                gp_d[k]  = gp_q[k-1] & p_shift;
                p_d[k]   = p_q[k-1];
                cin_d[k] = cin_q[k-1];
                vld_d[k] = vld_q[k-1];
            end

            // Sum stage: carry into bit i is the group generate of bits
            // [i-1:0]; carry into bit 0 is cin itself.
            carry     = {gg_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
            sum       = p_q[LEVELS] ^ carry;
            out0_d    = {gg_q[LEVELS][WIDTH-1], sum};
            out_vld_d = vld_q[LEVELS];
        end
    end

    // Control state: valid bits and the visible result are reset; in-flight
    // beats die with their valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= LEVELS; k++) begin
                vld_q[k] <= 1'b0;
            end
            out_vld_q <= 1'b0;
            out0_q    <= '0;
        end else begin
            for (int k = 0; k <= LEVELS; k++) begin
                vld_q[k] <= vld_d[k];
            end
            out_vld_q <= out_vld_d;
            out0_q    <= out0_d;
        end
    end

    // Datapath registers carry no reset; their contents only matter under a
    // set valid bit.
    always_ff @(posedge clk) begin
        for (int k = 0; k <= LEVELS; k++) begin
            gg_q[k]  <= gg_d[k];
            gp_q[k]  <= gp_d[k];
            p_q[k]   <= p_d[k];
            cin_q[k] <= cin_d[k];
        end
    end

endmodule

// File: doc/ks_adder_pipe.md
Name: ks_adder_pipe

Overview:
Parametrised, fully pipelined Kogge-Stone parallel-prefix adder. Successor to the fixed 16-bit combinational KS adder: generic operand width, carry-in, one register stage per prefix level, and a valid/ready stream interface with backpressure. Used as the exact baseline in the ALS benchmark flow and as a drop-in datapath adder in streaming designs; driven from the same dataset-file testbench style, now clocked.

Parameters:
WIDTH, 16, operand width in bits; legal range ≥ 2, need not be a power of two.
LEVELS, $clog2(WIDTH), derived localparam: number of Kogge-Stone prefix levels; not overridable.
LATENCY, LEVELS+2, derived localparam: input-to-output latency in cycles when not stalled (6 for WIDTH=16).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts a beat this cycle.
in0  input  WIDTH  operand A, unsigned.
in1  input  WIDTH  operand B, unsigned.
cin  input  1  carry-in.
out_valid  output  1  out0 holds a valid result.
out_ready  input  1  downstream accepts the result.
out0  output  WIDTH+1  in0 + in1 + cin; MSB is carry-out.

Behaviour:
- Reset (rst=1 at a clock edge): all stage valid bits cleared; out_valid=0; out0=0. Internal data registers need not be cleared. Reset overrides every other input in that cycle; in-flight beats are discarded, never emitted.
- Stage 0 (input register): captures in0, in1, cin; forms g_i=a_i&b_i, p_i=a_i^b_i, with cin folded into bit 0 as g_0 = a_0&b_0 | (a_0^b_0)&cin.
- Stages 1..LEVELS: prefix level k combines (G,P) at bit i with bit i-2^(k-1) when i ≥ 2^(k-1); otherwise passes through. Registers after every level. Original p_i and cin carried alongside.
- Final stage: sum_i = p_i ^ c_i (c_0=cin, c_i=G_{i-1}); out0[WIDTH] = G_{WIDTH-1}; registered into out0.
- Result must equal (in0 + in1 + cin) mod 2^(WIDTH+1) for every input; no overflow case exists.
- Global stall: en = !(out_valid && !out_ready). in_ready = en (combinational, depends on out_valid register and out_ready only; not on in_valid).
- When en=1, every stage advances one step; stage-0 valid loads (in_valid && in_ready). When en=0, all stages and out0 hold; out0 and out_valid stable until accepted.
- Transfer at output occurs when out_valid && out_ready; a result is emitted exactly once.
- Bubbles are not compacted: an empty stage advances like a full one. Throughput 1 beat/cycle while out_ready=1.
- Ordering: results emerge in acceptance order; no reordering, no drop, no duplication.
- in_valid with in_ready=0: no capture; upstream must hold the beat (standard valid/ready).
- First result after reset available exactly LATENCY cycles after the accepting edge, absent stalls.

Test Plan:
- WIDTH=16, single beat in0=0xFFFF, in1=0x0001, cin=0, out_ready=1 -> out_valid rises 6 cycles after acceptance, out0=0x10000, then drops.
- WIDTH=16, cin=1, in0=0xFFFF, in1=0xFFFF -> out0=0x1FFFF; in0=0x1234, in1=0x0000, cin=1 -> out0=0x01235.
- WIDTH=16, stream 3 back-to-back beats (0x0001+0x0002, 0x8000+0x8000, 0x00FF+0x0F01) -> outputs on 3 consecutive cycles: 0x00003, 0x10000, 0x01000.
- Backpressure: stream 8 beats, hold out_ready=0 for 4 cycles once out_valid=1 -> in_ready=0 during stall, out0 constant, all 8 results delivered in order, none lost or repeated.
- Reset mid-stream: 4 beats in flight, assert rst 1 cycle -> next cycle out_valid=0, out0=0; none of the 4 results ever appear; new beat after reset emerges 6 cycles later.
- WIDTH=8 instance (LATENCY=5): 0xFF+0x01 -> 0x100; plus 10^6 random vectors at WIDTH=16 with random out_ready, each result matching in0+in1+cin.
